cpu_lsu: RTL



---
 rtl/cpu_lsu_if.sv | 37 +++
 rtl/cpu_lsu.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/cpu_lsu_if.sv
// cpu_lsu_if: request/response and data-memory signals of the load/store unit
// slave modport = LSU view, master modport = core + memory view
interface cpu_lsu_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [4:0]        req_rd;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_rdata;
    logic [4:0]        rsp_rd;
    logic [1:0]        rsp_err;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN/8-1:0] mem_we;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_ready;
    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, req_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err,
        output mem_en, mem_addr, mem_we, mem_wdata,
        input  mem_rdata, mem_ready
    );
    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, req_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err,
        input  mem_en, mem_addr, mem_we, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/cpu_lsu.sv
// cpu_lsu: multicycle load/store unit turning core requests into aligned data-memory accesses
// ports: aclk, areset (async, active-high), bus = cpu_lsu_if.slave (req_*, rsp_*, mem_*)
module cpu_lsu #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic     aclk,
    input logic     areset,
    cpu_lsu_if.slave bus
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            r_state, w_state_n;
    logic              r_req_ready, w_req_ready_n;
    logic              r_rsp_valid, w_rsp_valid_n;
    logic [XLEN-1:0]   r_rsp_rdata, w_rsp_rdata_n;
    logic [4:0]        r_rsp_rd, w_rsp_rd_n;
    logic [1:0]        r_rsp_err, w_rsp_err_n;
    logic              r_mem_en, w_mem_en_n;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_n;
    logic [NB-1:0]     r_mem_we, w_mem_we_n;
    logic [XLEN-1:0]   r_mem_wdata, w_mem_wdata_n;
    logic [CW-1:0]     r_cnt, w_cnt_n;
    logic [1:0]        r_size, w_size_n;
    logic              r_uns, w_uns_n;
    logic [OW-1:0]     r_off, w_off_n;
    logic              r_store, w_store_n;

    logic              w_accept, w_mis, w_to, w_sgn;
    logic [OW-1:0]     w_off;
    logic [NB-1:0]     w_mask;
    logic [XLEN-1:0]   w_sh, w_keep, w_ld;

    assign w_accept = (r_state == IDLE) && r_req_ready && bus.req_valid;
    assign w_off    = bus.req_addr[OW-1:0];
    // double-word access is only legal on a 64-bit port
    assign w_mis    = (bus.req_size == 2'd1) ? bus.req_addr[0] :
                      (bus.req_size == 2'd2) ? |bus.req_addr[1:0] :
                      (bus.req_size == 2'd3) ? ((XLEN == 32) || |bus.req_addr[2:0]) : 1'b0;
    assign w_mask   = (bus.req_size == 2'd0) ? NB'(1) :
                      (bus.req_size == 2'd1) ? NB'(3) :
                      (bus.req_size == 2'd2) ? NB'(15) : NB'(255);
    // mem_ready in the same cycle as the limit wins, since it is checked first
    assign w_to     = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT));

    // load extraction: shift the addressed lane down, keep 8*2^size bits, fill the rest
    assign w_sh   = bus.mem_rdata >> {r_off, 3'b000};
    assign w_keep = (r_size == 2'd0) ? XLEN'(8'hFF) :
                    (r_size == 2'd1) ? XLEN'(16'hFFFF) :
                    (r_size == 2'd2) ? XLEN'(32'hFFFF_FFFF) : {XLEN{1'b1}};
    assign w_sgn  = ~r_uns & ((r_size == 2'd0) ? w_sh[7] :
                              (r_size == 2'd1) ? w_sh[15] :
                              (r_size == 2'd2) ? w_sh[31] : w_sh[XLEN-1]);
    assign w_ld   = (w_sh & w_keep) | ({XLEN{w_sgn}} & ~w_keep);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_rd    <= '0;
            r_rsp_err   <= '0;
            r_mem_en    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= '0;
            r_mem_wdata <= '0;
            r_cnt       <= '0;
            r_size      <= '0;
            r_uns       <= 1'b0;
            r_off       <= '0;
            r_store     <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_req_ready <= w_req_ready_n;
            r_rsp_valid <= w_rsp_valid_n;
            r_rsp_rdata <= w_rsp_rdata_n;
            r_rsp_rd    <= w_rsp_rd_n;
            r_rsp_err   <= w_rsp_err_n;
            r_mem_en    <= w_mem_en_n;
            r_mem_addr  <= w_mem_addr_n;
            r_mem_we    <= w_mem_we_n;
            r_mem_wdata <= w_mem_wdata_n;
            r_cnt       <= w_cnt_n;
            r_size      <= w_size_n;
            r_uns       <= w_uns_n;
            r_off       <= w_off_n;
            r_store     <= w_store_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        if (w_accept)
            w_state_n = w_mis ? RESP : ACCESS;
        else if (r_state == ACCESS && (bus.mem_ready || w_to))
            w_state_n = RESP;
        else if (r_state != IDLE && r_state != ACCESS)
            w_state_n = IDLE;
    end

    always_comb begin
        w_req_ready_n = (w_state_n == IDLE);
        w_rsp_valid_n = (w_state_n == RESP);
        w_cnt_n       = (r_state == ACCESS && !bus.mem_ready) ? r_cnt + 1'b1 : '0;
        w_rsp_rdata_n = r_rsp_rdata;
        w_rsp_rd_n    = r_rsp_rd;
        w_rsp_err_n   = r_rsp_err;
        w_mem_en_n    = r_mem_en;
        w_mem_addr_n  = r_mem_addr;
        w_mem_we_n    = r_mem_we;
        w_mem_wdata_n = r_mem_wdata;
        w_size_n      = r_size;
        w_uns_n       = r_uns;
        w_off_n       = r_off;
        w_store_n     = r_store;
        if (w_accept) begin
            w_rsp_rd_n    = bus.req_rd;
            w_rsp_err_n   = w_mis ? 2'd1 : 2'd0;
            w_rsp_rdata_n = '0;
            w_size_n      = bus.req_size;
            w_uns_n       = bus.req_unsigned;
            w_off_n       = w_off;
            w_store_n     = bus.req_store;
            if (!w_mis) begin
                w_mem_en_n    = 1'b1;
                w_mem_addr_n  = {bus.req_addr[ADDR_W-1:OW], {OW{1'b0}}};
                w_mem_we_n    = bus.req_store ? w_mask << w_off : '0;
                w_mem_wdata_n = bus.req_wdata << {w_off, 3'b000};
            end
        end else if (r_state == ACCESS && (bus.mem_ready || w_to)) begin
            w_mem_en_n    = 1'b0;
            w_mem_we_n    = '0;
            w_rsp_err_n   = bus.mem_ready ? 2'd0 : 2'd2;
            w_rsp_rdata_n = (bus.mem_ready && !r_store) ? w_ld : '0;
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_rd    = r_rsp_rd;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_wdata = r_mem_wdata;
endmodule
